// File: rtl/reg_pipe.sv
// rtl/reg_pipe.sv - enabled, clearable register pipeline with per-stage valid flags
// Occupancy counter and port occ are built only when REG_PIPE_OCC_EN is defined.
module reg_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
`ifdef REG_PIPE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

    logic [WIDTH-1:0] data_r  [DEPTH];
    logic             valid_r [DEPTH];

    // Stage 0 takes the input word; every later stage takes its predecessor.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i]  <= '0;
                valid_r[i] <= 1'b0;
            end
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i]  <= '0;
                valid_r[i] <= 1'b0;
            end
        end else if (en) begin
            data_r[0]  <= d;
            valid_r[0] <= d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_r[i]  <= data_r[i-1];
                valid_r[i] <= valid_r[i-1];
            end
        end
    end

    assign q       = data_r[DEPTH-1];
    assign q_valid = valid_r[DEPTH-1];

`ifdef REG_PIPE_OCC_EN
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [OCC_W-1:0] occ_r;

    // A word entering while another leaves cancels out; the count cannot
    // exceed DEPTH since a full pipe always has a valid last stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_r <= '0;
        end else if (clr) begin
            occ_r <= '0;
        end else if (en) begin
            occ_r <= occ_r + OCC_W'(d_valid) - OCC_W'(valid_r[DEPTH-1]);
        end
    end

    assign occ = occ_r;
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// tb/tb_reg_pipe.sv - randomized self-checking bench for reg_pipe against a queue model
// Occupancy checks compile in only when REG_PIPE_OCC_EN is defined.
module tb_reg_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int OCC_W = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] d = '0;
    logic             d_valid = 1'b0;
    logic [WIDTH-1:0] q;
    logic             q_valid;
`ifdef REG_PIPE_OCC_EN
    logic [OCC_W-1:0] occ;
`endif

    int checks = 0;
    int errors = 0;

    // Last DEPTH words accepted on enabled edges, oldest first; {valid, data}.
    logic [WIDTH:0] log_q[$];

    reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .clr     (clr),
        .d       (d),
        .d_valid (d_valid),
        .q       (q),
        .q_valid (q_valid)
`ifdef REG_PIPE_OCC_EN
        ,
        .occ     (occ)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH:0] exp_out();
        if (log_q.size() < DEPTH) return '0;
        return log_q[log_q.size()-DEPTH];
    endfunction

    function automatic int exp_occ();
        int n = 0;
        for (int i = 0; i < log_q.size(); i++)
            if (log_q[i][WIDTH]) n++;
        return n;
    endfunction

    // Drive one cycle from a negedge, update the model at the posedge, return at the next negedge.
    task automatic step(input logic e, input logic c, input logic [WIDTH-1:0] dd, input logic dv);
        en = e; clr = c; d = dd; d_valid = dv;
        @(posedge clk);
        if (!reset || c) begin
            log_q.delete();
        end else if (e) begin
            log_q.push_back({dv, dd});
            if (log_q.size() > DEPTH) void'(log_q.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [WIDTH:0] want;
        @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 1'b0, 8'hFF, 1'b1);
            checks++;
            if ({q_valid, q} !== 9'h000) begin
                errors++;
                $display("FAIL reset_hold edge %0d: got %h expected %h", k, {q_valid, q}, 9'h000);
            end
`ifdef REG_PIPE_OCC_EN
            checks++;
            if (occ !== '0) begin
                errors++;
                $display("FAIL reset_hold_occ edge %0d: got %0d expected 0", k, occ);
            end
`endif
        end
        reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 1'b0, 8'hFF, 1'b1);
            want = exp_out();
            checks++;
            if ({q_valid, q} !== want) begin
                errors++;
                $display("FAIL reset_release edge %0d: got %h expected %h", k, {q_valid, q}, want);
            end
        end
        checks++;
        if (q !== 8'hFF || q_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_final: got %h/%b expected ff/1", q, q_valid);
        end
    endtask

    task automatic test_latency();
        logic [WIDTH:0] want;
        step(1'b0, 1'b1, 8'h00, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 1'b0, (k == 1) ? 8'h38 : 8'hF0, 1'b1);
            want = exp_out();
            checks++;
            if ({q_valid, q} !== want) begin
                errors++;
                $display("FAIL latency edge %0d: got %h expected %h", k, {q_valid, q}, want);
            end
            if (k == 4) begin
                checks++;
                if (q !== 8'h38 || q_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL latency_first: got %h/%b expected 38/1", q, q_valid);
                end
            end
            if (k == 5) begin
                checks++;
                if (q !== 8'hF0 || q_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL latency_second: got %h/%b expected f0/1", q, q_valid);
                end
            end
        end
    endtask

    task automatic test_hold();
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'hA5, 1'b1);
        step(1'b1, 1'b0, 8'($urandom), 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b0, 8'($urandom), 1'b1);
            checks++;
            if (q_valid !== 1'b0 || {q_valid, q} !== exp_out()) begin
                errors++;
                $display("FAIL hold cycle %0d: got %h expected %h", k, {q_valid, q}, exp_out());
            end
        end
        step(1'b1, 1'b0, 8'($urandom), 1'b0);
        step(1'b1, 1'b0, 8'($urandom), 1'b0);
        checks++;
        if (q !== 8'hA5 || q_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got %h/%b expected a5/1", q, q_valid);
        end
    endtask

    task automatic test_clr_priority();
        step(1'b0, 1'b1, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 8'($urandom), 1'b1);
        checks++;
        if ({q_valid, q} !== exp_out()) begin
            errors++;
            $display("FAIL clr_full_q: got %h expected %h", {q_valid, q}, exp_out());
        end
`ifdef REG_PIPE_OCC_EN
        checks++;
        if (occ !== OCC_W'(4)) begin
            errors++;
            $display("FAIL clr_full_occ: got %0d expected 4", occ);
        end
`endif
        step(1'b1, 1'b1, 8'hAA, 1'b1);
        checks++;
        if (q !== 8'h00 || q_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_priority: got %h/%b expected 00/0", q, q_valid);
        end
`ifdef REG_PIPE_OCC_EN
        checks++;
        if (occ !== '0) begin
            errors++;
            $display("FAIL clr_priority_occ: got %0d expected 0", occ);
        end
`endif
        for (int k = 1; k <= 3; k++) step(1'b1, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({q_valid, q} !== 9'h000) begin
            errors++;
            $display("FAIL clr_not_captured: got %h expected %h", {q_valid, q}, 9'h000);
        end
    endtask

    task automatic test_occ();
        step(1'b0, 1'b1, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 8'($urandom), 1'b1);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0, 8'($urandom), (k <= 4));
            checks++;
            if ({q_valid, q} !== exp_out()) begin
                errors++;
                $display("FAIL occ_stream_q edge %0d: got %h expected %h", k, {q_valid, q}, exp_out());
            end
`ifdef REG_PIPE_OCC_EN
            checks++;
            if (occ !== OCC_W'((k <= 4) ? 4 : 8 - k)) begin
                errors++;
                $display("FAIL occ_stream edge %0d: got %0d expected %0d", k, occ, (k <= 4) ? 4 : 8 - k);
            end
`endif
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b1, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 8'($urandom), 1'b1);
        step(1'b1, 1'b0, 8'h11, 1'b0);
        step(1'b1, 1'b0, 8'h22, 1'b0);
        checks++;
        if (q_valid !== 1'b1 || exp_occ() != 2) begin
            errors++;
            $display("FAIL async_setup: got q_valid %b model occ %0d expected 1 and 2", q_valid, exp_occ());
        end
        en = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({q_valid, q} !== 9'h000) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", {q_valid, q}, 9'h000);
        end
`ifdef REG_PIPE_OCC_EN
        checks++;
        if (occ !== '0) begin
            errors++;
            $display("FAIL async_reset_occ: got %0d expected 0", occ);
        end
`endif
        log_q.delete();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 8'h5A, 1'b1);
        checks++;
        if (q !== 8'h5A || q_valid !== 1'b1) begin
            errors++;
            $display("FAIL async_recover: got %h/%b expected 5a/1", q, q_valid);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 8'($urandom), 1'($urandom_range(0, 1)));
            checks++;
            if ({q_valid, q} !== exp_out()) begin
                errors++;
                $display("FAIL random cycle %0d: got %h expected %h", k, {q_valid, q}, exp_out());
            end
`ifdef REG_PIPE_OCC_EN
            checks++;
            if (occ !== OCC_W'(exp_occ())) begin
                errors++;
                $display("FAIL random_occ cycle %0d: got %0d expected %0d", k, occ, exp_occ());
            end
`endif
            if (k % 50 == 49) begin
                #2 reset = 1'b0;
                #1;
                checks++;
                if ({q_valid, q} !== 9'h000) begin
                    errors++;
                    $display("FAIL random_reset cycle %0d: got %h expected %h", k, {q_valid, q}, 9'h000);
                end
                log_q.delete();
                reset = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_hold();
        test_clr_priority();
        test_occ();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_pipe.md
REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits; SHALL be legal for any value >= 1.
REQ-002 Parameter DEPTH, default 4, number of register stages (input-to-output latency); SHALL be legal for any value >= 1.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 reset  input  1  asynchronous, active-low reset; SHALL act as soon as reset=0, independent of clk.
REQ-005 en  input  1  advance enable; 1 = pipeline shifts one stage this edge, 0 = hold.
REQ-006 clr  input  1  synchronous clear of all stages.
REQ-007 d  input  WIDTH  input data word.
REQ-008 d_valid  input  1  qualifies d.
REQ-009 q  output  WIDTH  data word from last stage, driven directly from a register.
REQ-010 q_valid  output  1  valid flag of last stage, driven directly from a register.
REQ-011 occ  output  clog2(DEPTH+1)  count of valid stages, 0..DEPTH; present only with REG_PIPE_OCC_EN (REQ-024).

Function
REQ-012 Each stage i (0..DEPTH-1) SHALL hold a WIDTH-bit data word and a 1-bit valid flag.
REQ-013 On a rising edge with clr=0, en=1: stage 0 SHALL load {d, d_valid}; stage i SHALL load stage i-1 for i=1..DEPTH-1.
REQ-014 On a rising edge with clr=0, en=0: all stages (data and valid) SHALL hold their values.
REQ-015 On a rising edge with clr=1: all data and valid flags SHALL become 0, regardless of en; clr SHALL have priority over en.
REQ-016 Latency: a word presented with en=1 at edge k SHALL appear on q/q_valid after the DEPTH-th edge with en=1, counting edge k as the first; held cycles (en=0) SHALL not count.
REQ-017 Data SHALL be captured whether or not d_valid=1; q is meaningful only when q_valid=1.
REQ-018 DEPTH=1 SHALL behave as a single enabled register with valid flag: q, q_valid follow d, d_valid one enabled edge later.
REQ-019 No combinational path SHALL exist from any input to any output.

Reset
REQ-020 While reset=0: all stage data, all valid flags, q, q_valid and occ SHALL be 0; en, clr, d and d_valid SHALL be ignored.
REQ-021 Reset asserted mid-operation SHALL clear every stage immediately, without waiting for a clk edge; words in flight are discarded.
REQ-022 After reset returns to 1, the first rising edge SHALL operate normally per REQ-013..REQ-015.

Configuration
REQ-023 Macro REG_PIPE_OCC_EN SHALL select whether the occupancy counter is built.
REQ-024 With REG_PIPE_OCC_EN defined: port occ SHALL exist as a registered counter equal to the number of stages with valid=1 after each edge.
REQ-025 occ update with REG_PIPE_OCC_EN: en=1 adds d_valid and subtracts the last-stage valid flag, so simultaneous enter and exit leaves occ unchanged; en=0 holds occ; clr=1 or reset=0 sets occ to 0.
REQ-026 occ SHALL never exceed DEPTH and never go below 0.
REQ-027 Without REG_PIPE_OCC_EN: port occ and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 reset=0 with d=8'hFF, d_valid=1, en=1 for 3 edges -> q=8'h00, q_valid=0 (occ=0) throughout; reset released, same stimulus for 4 edges -> q=8'hFF, q_valid=1 after 4th edge.
REQ-029 DEPTH=4, en=1; d=8'h38, d_valid=1 for 1 edge, then d=8'hF0, d_valid=1 -> q=8'h38 after edge 4, q=8'hF0 after edge 5.
REQ-030 8'hA5 valid entered, en=1 for 2 edges, en=0 for 5 edges, en=1 for 2 edges -> q stays invalid while held; q=8'hA5, q_valid=1 after the 4th enabled edge.
REQ-031 Pipeline full (4 valid words, occ=4), clr=1 and en=1 on the same edge -> q=0, q_valid=0, occ=0 next cycle; d is not captured.
REQ-032 Pipeline full, continuous d_valid=1, en=1 -> occ stays 4 (enter and exit cancel); then d_valid=0 for 4 edges -> occ goes 3,2,1,0.
REQ-033 Pipeline holding 2 valid words, reset pulsed low between clk edges -> q_valid=0 and occ=0 before the next clk edge.
